// File: rtl/factor_candidate_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | factor_candidate_scanner                                                    |
// | Walks every (c1, c2) factor pair past a combinational formula block,        |
// | counts accepted pairs and flags disagreements with a golden multiply.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module factor_candidate_scanner #(
  parameter int W             = 5,
  parameter int SYM           = 0,
  parameter int STOP_ON_FIRST = 0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             abort,
  input  logic [2*W-1:0]   target,
  output logic             cand_valid,
  output logic [W-1:0]     cand_i1,
  output logic [W-1:0]     cand_i2,
  output logic [2*W-1:0]   cand_tgt,
  input  logic             cand_ok,
  output logic             busy,
  output logic             done,
  output logic             found,
  output logic [W-1:0]     f1,
  output logic [W-1:0]     f2,
  output logic [2*W:0]     sol_count,
  output logic             mismatch,
  output logic [W-1:0]     mm_i1,
  output logic [W-1:0]     mm_i2
);

  localparam logic [W-1:0] c_max     = {W{1'b1}};
  localparam logic [W-1:0] c_one     = {{(W-1){1'b0}}, 1'b1};
  localparam logic [2*W:0] c_cnt_one = {{(2*W){1'b0}}, 1'b1};

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SCAN = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t         r_state;
  state_t         w_next;
  logic [W-1:0]   r_c1;
  logic [W-1:0]   r_c2;
  logic [2*W-1:0] r_tgt;
  logic           r_found;
  logic [W-1:0]   r_f1;
  logic [W-1:0]   r_f2;
  logic [2*W:0]   r_count;
  logic           r_mm;
  logic [W-1:0]   r_mm_i1;
  logic [W-1:0]   r_mm_i2;

  logic [2*W-1:0] w_prod;
  logic           w_expected;
  logic           w_last;
  logic           w_stop;

  // Full-width product; trivial factor 1 never counts as a factorization.
  assign w_prod     = {{W{1'b0}}, r_c1} * {{W{1'b0}}, r_c2};
  assign w_expected = (w_prod == r_tgt) && (r_c1 != c_one) && (r_c2 != c_one);
  assign w_last     = (r_c1 == c_max) && (r_c2 == c_max);
  assign w_stop     = w_last || ((STOP_ON_FIRST != 0) && cand_ok);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next;
    end
  end

  always_comb begin
    w_next = r_state;
    case (r_state)
      S_IDLE: if (start) w_next = S_SCAN;
      S_SCAN: begin
        if (abort)       w_next = S_IDLE;
        else if (w_stop) w_next = S_DONE;
      end
      S_DONE:  w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_c1    <= '0;
      r_c2    <= '0;
      r_tgt   <= '0;
      r_found <= 1'b0;
      r_f1    <= '0;
      r_f2    <= '0;
      r_count <= '0;
      r_mm    <= 1'b0;
      r_mm_i1 <= '0;
      r_mm_i2 <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_tgt   <= target;
            r_found <= 1'b0;
            r_f1    <= '0;
            r_f2    <= '0;
            r_count <= '0;
            r_mm    <= 1'b0;
            r_mm_i1 <= '0;
            r_mm_i2 <= '0;
            r_c1    <= '0;
            r_c2    <= '0;
          end
        end
        S_SCAN: begin
          // Abort wins over anything this cycle would otherwise record.
          if (!abort) begin
            if (cand_ok) begin
              r_count <= r_count + c_cnt_one;
              if (!r_found) begin
                r_found <= 1'b1;
                r_f1    <= r_c1;
                r_f2    <= r_c2;
              end
            end
            if (cand_ok != w_expected) begin
              r_mm <= 1'b1;
              if (!r_mm) begin
                r_mm_i1 <= r_c1;
                r_mm_i2 <= r_c2;
              end
            end
            if (!w_stop) begin
              if (r_c2 == c_max) begin
                r_c1 <= r_c1 + c_one;
                r_c2 <= (SYM != 0) ? (r_c1 + c_one) : '0;
              end else begin
                r_c2 <= r_c2 + c_one;
              end
            end
          end
        end
        default: ;
      endcase
    end
  end

  assign cand_valid = (r_state == S_SCAN);
  assign busy       = (r_state == S_SCAN);
  assign done       = (r_state == S_DONE);
  assign cand_i1    = r_c1;
  assign cand_i2    = r_c2;
  assign cand_tgt   = r_tgt;
  assign found      = r_found;
  assign f1         = r_f1;
  assign f2         = r_f2;
  assign sol_count  = r_count;
  assign mismatch   = r_mm;
  assign mm_i1      = r_mm_i1;
  assign mm_i2      = r_mm_i2;

endmodule
`default_nettype wire

// File: tb/tb_factor_candidate_scanner.sv
`default_nettype none
// +-----------------------------------------------------------------------------+
// | tb_factor_candidate_scanner                                                 |
// | Three scanner variants (full grid, stop-on-first, symmetric) fed by a       |
// | formula stand-in, checked against a pair-enumeration reference model.       |
// | Revision: 1.0                                                               |
// +-----------------------------------------------------------------------------+
module tb_factor_candidate_scanner;

  localparam int W = 5;
  localparam int NV = 1 << W;

  typedef struct {
    int d, tgt, hold, fen, fi1, fi2;
    int n, cnt, fnd, f1, f2, mm, mi1, mi2;
  } scen_t;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic [2:0] start_v = '0;
  logic [2:0] abort_v = '0;
  logic [2*W-1:0] target = '0;
  int force_en = 0, force_i1 = 0, force_i2 = 0;
  int errors = 0, checks = 0;

  wire [2:0] cand_ok_v, cand_valid_v, busy_v, done_v, found_v, mismatch_v;
  wire [2:0][W-1:0] cand_i1_v, cand_i2_v, f1_v, f2_v, mm_i1_v, mm_i2_v;
  wire [2:0][2*W-1:0] cand_tgt_v;
  wire [2:0][2*W:0] sol_count_v;

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    factor_candidate_scanner #(
      .W(W), .SYM(g == 2 ? 1 : 0), .STOP_ON_FIRST(g == 1 ? 1 : 0)
    ) u_dut (
      .clk(clk), .rst_n(rst_n), .start(start_v[g]), .abort(abort_v[g]),
      .target(target), .cand_valid(cand_valid_v[g]),
      .cand_i1(cand_i1_v[g]), .cand_i2(cand_i2_v[g]), .cand_tgt(cand_tgt_v[g]),
      .cand_ok(cand_ok_v[g]), .busy(busy_v[g]), .done(done_v[g]),
      .found(found_v[g]), .f1(f1_v[g]), .f2(f2_v[g]), .sol_count(sol_count_v[g]),
      .mismatch(mismatch_v[g]), .mm_i1(mm_i1_v[g]), .mm_i2(mm_i2_v[g])
    );
    // Formula stand-in, with an optional flipped verdict at one chosen pair.
    assign cand_ok_v[g] = cand_valid_v[g] &
        (((int'(cand_i1_v[g]) * int'(cand_i2_v[g]) == int'(cand_tgt_v[g])) &&
          cand_i1_v[g] != 1 && cand_i2_v[g] != 1) ^
         (force_en != 0 && int'(cand_i1_v[g]) == force_i1 && int'(cand_i2_v[g]) == force_i2));
  end

  task automatic model(input int sym, input int stop, input int tgt, input int fen,
                       input int fi1, input int fi2, output int n, output int cnt,
                       output int fnd, output int f1, output int f2, output int mm,
                       output int mi1, output int mi2);
    int truth, ok, stp;
    n = 0; cnt = 0; fnd = 0; f1 = 0; f2 = 0; mm = 0; mi1 = 0; mi2 = 0; stp = 0;
    for (int a = 0; a < NV && stp == 0; a++) begin
      for (int b = (sym != 0 ? a : 0); b < NV && stp == 0; b++) begin
        truth = (a * b == tgt && a != 1 && b != 1) ? 1 : 0;
        ok = truth ^ ((fen != 0 && a == fi1 && b == fi2) ? 1 : 0);
        n++;
        if (ok != truth && mm == 0) begin mm = 1; mi1 = a; mi2 = b; end
        if (ok != 0) begin
          cnt++;
          if (fnd == 0) begin fnd = 1; f1 = a; f2 = b; end
          if (stop != 0) stp = 1;
        end
      end
    end
  endtask

  // Starts DUT d and follows it to the end; records what it observed.
  task automatic run_scan(input int d, input int tgt, input int hold, output int n,
                          output int seq_bad, output int done_w, output int tout);
    int e1, e2;
    logic [2*W-1:0] lt;
    n = 0; seq_bad = 0; done_w = 0; tout = 0; e1 = 0; e2 = 0;
    lt = tgt[2*W-1:0];
    @(negedge clk);
    target = lt;
    start_v[d] = 1'b1;
    @(negedge clk);
    while (busy_v[d] === 1'b1 && n < 2000) begin
      if (n >= hold) start_v[d] = 1'b0;
      if (hold > 0 && n == hold) target = ~lt;
      if (cand_i1_v[d] !== e1[W-1:0] || cand_i2_v[d] !== e2[W-1:0] ||
          cand_tgt_v[d] !== lt || cand_valid_v[d] !== 1'b1) seq_bad++;
      n++;
      e2++;
      if (e2 == NV) begin e1++; e2 = (d == 2) ? e1 : 0; end
      @(negedge clk);
    end
    start_v[d] = 1'b0;
    if (n >= 2000) tout = 1;
    while (done_v[d] === 1'b1 && done_w < 5) begin done_w++; @(negedge clk); end
  endtask

  task automatic test_reset();
    int obs[8];
    string nm[8];
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    obs = '{int'(busy_v), int'(done_v), int'(found_v), int'(mismatch_v), int'(cand_valid_v),
            int'(sol_count_v[0]) + int'(sol_count_v[2]), int'(cand_tgt_v[0]) + int'(cand_i2_v[1]),
            int'(f1_v[0]) + int'(f2_v[0]) + int'(mm_i1_v[0]) + int'(mm_i2_v[0]) + int'(cand_i1_v[0])};
    nm = '{"busy", "done", "found", "mismatch", "cand_valid", "sol_count", "cand_tgt_i2", "regs"};
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (obs[k] !== 0) begin
        errors++;
        $display("FAIL reset_%s got %0d want 0", nm[k], obs[k]);
      end
    end
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_scans();
    scen_t q[$];
    scen_t s;
    int n, seq_bad, done_w, tout, a, b;
    int obs[11], exp[11];
    string nm[11];
    nm = '{"latency", "done_width", "sequence", "timeout", "found", "f1", "f2",
           "sol_count", "mismatch", "mm_i1", "mm_i2"};
    q.push_back('{0, 15,  0,   0, 0, 0, 1024, 2, 1, 3, 5, 0, 0, 0});
    q.push_back('{0, 13,  0,   0, 0, 0, 1024, 0, 0, 0, 0, 0, 0, 0});
    q.push_back('{0, 0,   0,   0, 0, 0, 1024, 61, 1, 0, 0, 0, 0, 0});
    q.push_back('{0, 961, 0,   0, 0, 0, 1024, 1, 1, 31, 31, 0, 0, 0});
    q.push_back('{1, 15,  0,   0, 0, 0, 102, 1, 1, 3, 5, 0, 0, 0});
    q.push_back('{2, 15,  0,   0, 0, 0, 528, 1, 1, 3, 5, 0, 0, 0});
    q.push_back('{0, 4,   0,   1, 2, 3, 1024, 2, 1, 2, 2, 1, 2, 3});
    q.push_back('{0, 15,  300, 0, 0, 0, 1024, 2, 1, 3, 5, 0, 0, 0});
    for (int r = 0; r < 7; r++) begin
      s.d = $urandom_range(0, 2);
      a = $urandom_range(0, NV - 1);
      b = $urandom_range(0, NV - 1);
      s.tgt = ($urandom_range(0, 1) == 1) ? a * b : $urandom_range(0, NV * NV - 1);
      s.hold = 0;
      s.fen = $urandom_range(0, 1);
      s.fi1 = $urandom_range(0, NV - 1);
      s.fi2 = $urandom_range(0, NV - 1);
      model(s.d == 2 ? 1 : 0, s.d == 1 ? 1 : 0, s.tgt, s.fen, s.fi1, s.fi2,
            s.n, s.cnt, s.fnd, s.f1, s.f2, s.mm, s.mi1, s.mi2);
      q.push_back(s);
    end
    foreach (q[i]) begin
      s = q[i];
      force_en = s.fen; force_i1 = s.fi1; force_i2 = s.fi2;
      run_scan(s.d, s.tgt, s.hold, n, seq_bad, done_w, tout);
      force_en = 0;
      obs = '{n, done_w, seq_bad, tout, int'(found_v[s.d]), int'(f1_v[s.d]), int'(f2_v[s.d]),
              int'(sol_count_v[s.d]), int'(mismatch_v[s.d]), int'(mm_i1_v[s.d]), int'(mm_i2_v[s.d])};
      exp = '{s.n, 1, 0, 0, s.fnd, s.f1, s.f2, s.cnt, s.mm, s.mi1, s.mi2};
      for (int k = 0; k < 11; k++) begin
        checks++;
        if (obs[k] !== exp[k]) begin
          errors++;
          $display("FAIL scan%0d_%s (dut%0d tgt=%0d) got %0d want %0d",
                   i, nm[k], s.d, s.tgt, obs[k], exp[k]);
        end
      end
    end
  endtask

  task automatic test_abort();
    int obs[8], exp[8], pulses;
    string nm[8];
    nm = '{"busy", "done", "sol_count", "found", "f1", "f2", "cand_i2", "done_later"};
    @(negedge clk);
    target = '0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    for (int k = 1; k < 10; k++) @(negedge clk);
    abort_v[0] = 1'b1;
    @(negedge clk);
    abort_v[0] = 1'b0;
    pulses = 0;
    for (int k = 0; k < 4; k++) begin
      if (k > 0 && done_v[0] === 1'b1) pulses++;
      if (k < 3) @(negedge clk);
    end
    obs = '{int'(busy_v[0]), int'(done_v[0]), int'(sol_count_v[0]), int'(found_v[0]),
            int'(f1_v[0]), int'(f2_v[0]), int'(cand_i2_v[0]), pulses};
    exp = '{0, 0, 8, 1, 0, 0, 9, 0};
    for (int k = 0; k < 8; k++) begin
      checks++;
      if (obs[k] !== exp[k]) begin
        errors++;
        $display("FAIL abort_%s got %0d want %0d", nm[k], obs[k], exp[k]);
      end
    end
  endtask

  task automatic test_reset_mid_scan();
    int obs[7], pulses;
    string nm[7];
    nm = '{"busy", "cand_valid", "sol_count", "found", "cand_i2", "cand_tgt", "done_after"};
    @(negedge clk);
    target = 10'd0;
    start_v[0] = 1'b1;
    @(negedge clk);
    start_v[0] = 1'b0;
    repeat (50) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    pulses = 0;
    obs[0] = int'(busy_v[0]);
    obs[1] = int'(cand_valid_v[0]);
    obs[2] = int'(sol_count_v[0]);
    obs[3] = int'(found_v[0]);
    obs[4] = int'(cand_i2_v[0]);
    obs[5] = int'(cand_tgt_v[0]);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      if (done_v[0] === 1'b1 || busy_v[0] === 1'b1) pulses++;
    end
    obs[6] = pulses;
    for (int k = 0; k < 7; k++) begin
      checks++;
      if (obs[k] !== 0) begin
        errors++;
        $display("FAIL rstmid_%s got %0d want 0", nm[k], obs[k]);
      end
    end
  endtask

  initial begin
    test_reset();
    test_scans();
    test_abort();
    test_reset_mid_scan();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog simulation did not finish got timeout want completion");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
